// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// FSM state encoding, legal byte-enable shapes and the lane-legality test.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } state_e;

  localparam logic [3:0] BE_B0  = 4'b0001;
  localparam logic [3:0] BE_B1  = 4'b0010;
  localparam logic [3:0] BE_B2  = 4'b0100;
  localparam logic [3:0] BE_B3  = 4'b1000;
  localparam logic [3:0] BE_HLO = 4'b0011;
  localparam logic [3:0] BE_HHI = 4'b1100;
  localparam logic [3:0] BE_W   = 4'b1111;

  // 1 when be is not a legal shape or does not sit on the address lanes
  function automatic logic be_fault(
    input logic [1:0] lo,
    input logic [3:0] be
  );
    logic f;
    f = 1'b1;
    unique case (1'b1)
      (be == BE_B0):  f = (lo != 2'd0);
      (be == BE_B1):  f = (lo != 2'd1);
      (be == BE_B2):  f = (lo != 2'd2);
      (be == BE_B3):  f = (lo != 2'd3);
      (be == BE_HLO): f = (lo != 2'd0);
      (be == BE_HHI): f = (lo != 2'd2);
      (be == BE_W):   f = (lo != 2'd0);
      default:        f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/dmem_responder_bram.sv
// Single-port word RAM, per-byte write enable, registered read.
// Kept apart so block-RAM inference can be swapped per target.
module dmem_bram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic [3:0]            we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**ADDR_WIDTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int i = 0; i < 4; i++) begin
        if (we_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: request FSM, fault check, store aligner,
// load formatter around a synchronous word RAM.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic        req_we,
  input  logic        req_is_signed,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault
);

  localparam int WC1 = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [3:0]            be_q;
  logic                  we_q;
  logic                  sgn_q;
  logic                  fault_q;
  logic [31:0]           wdata_q;

  logic        accept;
  logic        bad_req;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] load_fmt;
  logic [15:0] half;
  logic [7:0]  byte_v;

  assign req_ready = (state_q == ST_IDLE) & resetb;
  assign accept    = req_valid & req_ready;
  assign bad_req   = be_fault(req_addr[1:0], req_be)
                   | ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bad_req) begin
            state_d = ST_RESP;
          end else if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = 3'(WC1);
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_ACCESS;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      fault_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= req_addr[ADDR_WIDTH+1:0];
        be_q    <= req_be;
        we_q    <= req_we;
        sgn_q   <= req_is_signed;
        fault_q <= bad_req;
        wdata_q <= req_wdata;
      end
    end
  end

  // resetb gating suppresses a write on an ACCESS edge that is also reset
  assign ram_en = (state_q == ST_ACCESS) & resetb;
  assign ram_we = we_q ? be_q : 4'b0000;

  always_comb begin
    ram_wdata = {4{wdata_q[7:0]}};
    unique case (1'b1)
      (be_q == BE_W):   ram_wdata = wdata_q;
      (be_q == BE_HLO),
      (be_q == BE_HHI): ram_wdata = {2{wdata_q[15:0]}};
      default:          ram_wdata = {4{wdata_q[7:0]}};
    endcase
  end

  dmem_bram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_bram (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (addr_q[ADDR_WIDTH+1:2]),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    half     = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    byte_v   = ram_rdata[{addr_q[1:0], 3'b000} +: 8];
    load_fmt = {{24{sgn_q & byte_v[7]}}, byte_v};
    unique case (1'b1)
      (be_q == BE_W):   load_fmt = ram_rdata;
      (be_q == BE_HLO),
      (be_q == BE_HHI): load_fmt = {{16{sgn_q & half[15]}}, half};
      default:          load_fmt = {{24{sgn_q & byte_v[7]}}, byte_v};
    endcase
  end

  assign resp_valid = (state_q == ST_RESP) & resetb;
  assign resp_fault = resp_valid & fault_q;
  assign resp_rdata = (resp_valid & ~fault_q & ~we_q) ? load_fmt : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-level memory model.
// Two instances: no wait states and three wait states.
module tb_dmem_responder;

  logic        clk;
  logic        resetb        [2];
  logic        req_valid     [2];
  logic        req_ready     [2];
  logic [31:0] req_addr      [2];
  logic [3:0]  req_be        [2];
  logic        req_we        [2];
  logic        req_is_signed [2];
  logic [31:0] req_wdata     [2];
  logic        resp_valid    [2];
  logic [31:0] resp_rdata    [2];
  logic        resp_fault    [2];

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] mdl [2][16];

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .resetb(resetb[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .req_be(req_be[0]), .req_we(req_we[0]),
    .req_is_signed(req_is_signed[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
    .resp_fault(resp_fault[0])
  );

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .resetb(resetb[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .req_be(req_be[1]), .req_we(req_we[1]),
    .req_is_signed(req_is_signed[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
    .resp_fault(resp_fault[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wc(input int d);
    return (d == 1) ? 3 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: a request is legal when be is a contiguous run of 1, 2
  // or 4 bytes starting at addr%4, naturally aligned, and inside 4 KiB.
  task automatic model(input int d, input logic [31:0] addr,
                       input logic [3:0] be, input logic we,
                       input logic sgn, input logic [31:0] wdata,
                       output logic flt, output logic [31:0] rd);
    int size;
    int off;
    logic [3:0] shape;
    logic [31:0] w;
    logic [63:0] v;
    logic [63:0] mask;
    size = $countones(be);
    off = 0;
    for (int i = 3; i >= 0; i--) if (be[i]) off = i;
    rd = 32'd0;
    flt = 1'b0;
    if (!(size == 1 || size == 2 || size == 4)) flt = 1'b1;
    else begin
      shape = 4'(((1 << size) - 1) << off);
      if (be != shape) flt = 1'b1;
      if (off != int'(addr[1:0])) flt = 1'b1;
      if ((addr % size) != 0) flt = 1'b1;
    end
    if (addr >= 32'd4096) flt = 1'b1;
    if (flt) return;
    w = mdl[d][addr[5:2]];
    if (we) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) w[8*i +: 8] = wdata[8*(i-off) +: 8];
      mdl[d][addr[5:2]] = w;
    end else begin
      v = {32'd0, w} >> (8 * off);
      if (size < 4) begin
        mask = (64'd1 << (8 * size)) - 64'd1;
        v = v & mask;
        if (sgn && v[8*size-1]) v = v | ~mask;
      end
      rd = v[31:0];
    end
  endtask

  task automatic drive(input int d, input logic [31:0] addr,
                       input logic [3:0] be, input logic we,
                       input logic sgn, input logic [31:0] wdata);
    req_addr[d] = addr;
    req_be[d] = be;
    req_we[d] = we;
    req_is_signed[d] = sgn;
    req_wdata[d] = wdata;
  endtask

  task automatic issue(input int d, input logic [31:0] addr,
                       input logic [3:0] be, input logic we,
                       input logic sgn, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic flt,
                       output int lat);
    int w;
    logic seen;
    rd = 32'hx;
    flt = 1'bx;
    @(negedge clk);
    drive(d, addr, be, we, sgn, wdata);
    req_valid[d] = 1'b1;
    w = 0;
    while (!req_ready[d] && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid[d] = 1'b0;
      lat = -1;
      return;
    end
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (resp_valid[d]) begin
        seen = 1'b1;
        rd = resp_rdata[d];
        flt = resp_fault[d];
      end
    end
    if (!seen) check("resp_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("resp_width", 32'(resp_valid[d]), 32'd0);
  endtask

  task automatic run(input int d, input logic [31:0] addr,
                     input logic [3:0] be, input logic we,
                     input logic sgn, input logic [31:0] wdata,
                     output logic [31:0] rd);
    logic ef;
    logic [31:0] er;
    logic flt;
    int lat;
    model(d, addr, be, we, sgn, wdata, ef, er);
    issue(d, addr, be, we, sgn, wdata, rd, flt, lat);
    check("latency", 32'(lat), ef ? 32'd1 : 32'(2 + wc(d)));
    check("fault", 32'(flt), 32'(ef));
    check("rdata", rd, er);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0] be;
    logic ef;
    logic [31:0] er;
    int size;
    int off;
    int r;
    int k;
    int lat_a;
    logic got_ready;
    logic seen;

    for (int d = 0; d < 2; d++) begin
      resetb[d] = 1'b0;
      req_valid[d] = 1'b0;
      drive(d, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
      for (int w = 0; w < 16; w++) mdl[d][w] = 32'd0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", 32'(req_ready[d]), 32'd0);
      check("rst_valid", 32'(resp_valid[d]), 32'd0);
      check("rst_rdata", resp_rdata[d], 32'd0);
      check("rst_fault", 32'(resp_fault[d]), 32'd0);
    end
    resetb[0] = 1'b1;
    resetb[1] = 1'b1;
    #1;
    check("ready_after_rst0", 32'(req_ready[0]), 32'd1);
    check("ready_after_rst1", 32'(req_ready[1]), 32'd1);

    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 16; w++)
        run(d, 32'(w * 4), 4'hF, 1'b1, 1'b0, 32'd0, rd);

    // directed word/byte/half traffic, no wait states
    run(0, 32'h10, 4'hF, 1'b1, 1'b0, 32'hDEADBEEF, rd);
    run(0, 32'h10, 4'hF, 1'b0, 1'b0, 32'h0, rd);
    check("lw_deadbeef", rd, 32'hDEADBEEF);
    run(0, 32'h13, 4'h8, 1'b1, 1'b0, 32'h000000A5, rd);
    run(0, 32'h13, 4'h8, 1'b0, 1'b1, 32'h0, rd);
    check("lb_signed", rd, 32'hFFFFFFA5);
    run(0, 32'h13, 4'h8, 1'b0, 1'b0, 32'h0, rd);
    check("lbu", rd, 32'h000000A5);
    run(0, 32'h10, 4'hF, 1'b0, 1'b0, 32'h0, rd);
    check("lw_after_sb", rd, 32'hA5ADBEEF);
    run(0, 32'h12, 4'hC, 1'b1, 1'b0, 32'h00008001, rd);
    run(0, 32'h12, 4'hC, 1'b0, 1'b1, 32'h0, rd);
    check("lh_signed", rd, 32'hFFFF8001);
    run(0, 32'h12, 4'hC, 1'b0, 1'b0, 32'h0, rd);
    check("lhu", rd, 32'h00008001);
    run(0, 32'h10, 4'hF, 1'b0, 1'b0, 32'h0, rd);
    check("lw_after_sh", rd, 32'h8001BEEF);

    run(0, 32'h10, 4'b0110, 1'b1, 1'b0, 32'h11111111, rd);
    run(0, 32'h10, 4'b0010, 1'b1, 1'b0, 32'h22222222, rd);
    run(0, 32'h1000, 4'hF, 1'b0, 1'b0, 32'h0, rd);
    run(0, 32'h10, 4'hF, 1'b0, 1'b0, 32'h0, rd);
    check("lw_after_faults", rd, 32'h8001BEEF);

    // three wait states: held second request accepted only after RESP
    wd = $urandom;
    model(1, 32'h24, 4'hF, 1'b1, 1'b0, wd, ef, er);
    @(negedge clk);
    drive(1, 32'h24, 4'hF, 1'b1, 1'b0, wd);
    req_valid[1] = 1'b1;
    k = 0;
    while (!req_ready[1] && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1 drive(1, 32'h24, 4'hF, 1'b0, 1'b0, 32'h0);
    k = 0;
    lat_a = 0;
    got_ready = 1'b0;
    while (!got_ready && k < 20) begin
      @(negedge clk);
      k++;
      if (resp_valid[1] && lat_a == 0) lat_a = k;
      if (req_ready[1]) got_ready = 1'b1;
    end
    check("wait_store_lat", 32'(lat_a), 32'd5);
    check("second_accept_off", 32'(k), 32'd6);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (resp_valid[1]) begin
        seen = 1'b1;
        rd = resp_rdata[1];
      end
    end
    check("second_lat", 32'(k), 32'd5);
    check("second_rdata", rd, wd);

    // reset pulse during WAIT aborts the store
    @(negedge clk);
    drive(1, 32'h20, 4'hF, 1'b1, 1'b0, 32'h12345678);
    req_valid[1] = 1'b1;
    k = 0;
    while (!req_ready[1] && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    seen = 1'b0;
    @(negedge clk);
    if (resp_valid[1]) seen = 1'b1;
    resetb[1] = 1'b0;
    @(negedge clk);
    if (resp_valid[1]) seen = 1'b1;
    resetb[1] = 1'b1;
    #1;
    check("rst_mid_ready", 32'(req_ready[1]), 32'd1);
    repeat (8) begin
      @(negedge clk);
      if (resp_valid[1]) seen = 1'b1;
    end
    check("rst_mid_no_resp", 32'(seen), 32'd0);
    run(1, 32'h20, 4'hF, 1'b0, 1'b0, 32'h0, rd);
    check("rst_mid_lw", rd, 32'd0);

    // randomized mix of legal and malformed requests
    for (int i = 0; i < 150; i++) begin
      for (int d = 0; d < 2; d++) begin
        r = $urandom_range(0, 9);
        size = 1 << $urandom_range(0, 2);
        off = $urandom_range(0, 3) & ~(size - 1);
        be = 4'(((1 << size) - 1) << off);
        a = 32'($urandom_range(0, 15) * 4 + off);
        if (r == 0) be = 4'($urandom_range(0, 15));
        if (r == 1) a = {a[31:2], 2'($urandom_range(0, 3))};
        if (r == 2) a = a | (32'h1000 << $urandom_range(0, 19));
        run(d, a, be, 1'($urandom), 1'($urandom), $urandom, rd);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
